queue_fwft: RTL and testbench

Parametrised first-word-fall-through FIFO: the generalised successor of the fixed 32-bit, 64-entry queue in the RISC core datapath. Width, depth and watermark levels are parameters. Storage is distributed (LUT) dual-port RAM with synchronous write and asynchronous read. The block adds an exact occupancy count, almost-full/almost-empty flags, and sticky overflow/underflow error flags; illegal reads and writes are guarded internally. Used for inter-unit message and DMA staging queues.

---
 rtl/queue_fwft_if.sv | 28 ++
 rtl/queue_fwft.sv | 94 +++++++++
 tb/tb_queue_fwft.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/queue_fwft_if.sv
// rtl/queue_fwft_if.sv - handshake and status bundle for the first-word-fall-through queue
interface queue_fwft_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 6
) ();
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic             err_clr;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output din, wr_en, rd_en, err_clr,
    input  dout, empty, full, count, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en, err_clr,
    output dout, empty, full, count, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/queue_fwft.sv
// rtl/queue_fwft.sv - parametrised FWFT queue with exact count, watermarks and sticky error flags
module queue_fwft #(
  parameter int WIDTH      = 32,
  parameter int AW         = 6,
  parameter int AFULL_LVL  = (1 << AW) - 4,
  parameter int AEMPTY_LVL = 2
) (
  input logic         clk,
  input logic         rst,
  queue_fwft_if.slave q
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] DEPTH_C  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AFULL_C  = (AW + 1)'(AFULL_LVL);
  localparam logic [AW:0] AEMPTY_C = (AW + 1)'(AEMPTY_LVL);

  if (WIDTH < 1 || WIDTH > 128 || AW < 2 || AW > 8 ||
      AFULL_LVL > DEPTH || AEMPTY_LVL >= DEPTH) begin : g_param_err
    $error("queue_fwft: illegal WIDTH/AW/watermark parameters");
  end

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]    ra;
  logic [AW-1:0]    wa;
  logic [AW:0]      cnt;
  logic             ovf;
  logic             udf;

  logic is_full;
  logic is_empty;
  logic wr_acc;
  logic rd_acc;
  logic ovf_set;
  logic udf_set;

  assign is_full  = (cnt == DEPTH_C);
  assign is_empty = (cnt == '0);

  // A simultaneous pop frees the slot, so a write at full is still taken.
  assign wr_acc  = q.wr_en & (~is_full | q.rd_en);
  assign rd_acc  = q.rd_en & ~is_empty;
  assign ovf_set = q.wr_en & is_full & ~q.rd_en;
  assign udf_set = q.rd_en & is_empty;

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wa] <= q.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra  <= '0;
      wa  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_acc) begin
        wa <= wa + 1'b1;
      end
      if (rd_acc) begin
        ra <= ra + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // Set has priority over clear so a coincident error is never lost.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (q.err_clr) begin
        ovf <= 1'b0;
      end
      if (udf_set) begin
        udf <= 1'b1;
      end else if (q.err_clr) begin
        udf <= 1'b0;
      end
    end
  end

  assign q.dout         = mem[ra];
  assign q.empty        = is_empty;
  assign q.full         = is_full;
  assign q.count        = cnt;
  assign q.almost_full  = (cnt >= AFULL_C);
  assign q.almost_empty = (cnt <= AEMPTY_C);
  assign q.overflow     = ovf;
  assign q.underflow    = udf;

endmodule

// File: tb/tb_queue_fwft.sv
// tb/tb_queue_fwft.sv - randomized and directed checks of queue_fwft against a queue-based model
module tb_queue_fwft;

  logic clk;
  logic rst_a;
  logic rst_b;

  queue_fwft_if #(.WIDTH(32), .AW(6)) qa ();
  queue_fwft_if #(.WIDTH(8),  .AW(3)) qb ();

  queue_fwft #(.WIDTH(32), .AW(6)) u_dut_a (.clk(clk), .rst(rst_a), .q(qa));
  queue_fwft #(.WIDTH(8),  .AW(3)) u_dut_b (.clk(clk), .rst(rst_b), .q(qb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mq[$];
  bit          m_ov;
  bit          m_un;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a();
    int n;
    n = mq.size();
    chk("a_count",  64'(qa.count), 64'(n));
    chk("a_empty",  64'(qa.empty), 64'(n == 0));
    chk("a_full",   64'(qa.full),  64'(n == 64));
    chk("a_afull",  64'(qa.almost_full),  64'(n >= 60));
    chk("a_aempty", 64'(qa.almost_empty), 64'(n <= 2));
    chk("a_ovf",    64'(qa.overflow),  64'(m_ov));
    chk("a_udf",    64'(qa.underflow), 64'(m_un));
    if (n > 0) chk("a_dout", 64'(qa.dout), 64'(mq[0]));
  endtask

  task automatic drive_a(input bit wr, input bit rd, input logic [31:0] d, input bit clr);
    qa.wr_en   = wr;
    qa.rd_en   = rd;
    qa.din     = d;
    qa.err_clr = clr;
  endtask

  task automatic step_a();
    bit full_m;
    bit empty_m;
    bit wr_ok;
    bit rd_ok;
    full_m  = (mq.size() == 64);
    empty_m = (mq.size() == 0);
    wr_ok   = qa.wr_en && (!full_m || qa.rd_en);
    rd_ok   = qa.rd_en && !empty_m;
    if (rst_a) begin
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (qa.wr_en && full_m && !qa.rd_en) m_ov = 1'b1;
      else if (qa.err_clr)                 m_ov = 1'b0;
      if (qa.rd_en && empty_m) m_un = 1'b1;
      else if (qa.err_clr)     m_un = 1'b0;
      if (rd_ok) void'(mq.pop_front());
      if (wr_ok) mq.push_back(qa.din);
    end
    @(posedge clk);
    #1;
    check_a();
  endtask

  task automatic step_b();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bdat [0:7];

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(1'b0, 1'b0, 32'h0, 1'b0);
    qb.wr_en = 1'b0; qb.rd_en = 1'b0; qb.din = 8'h0; qb.err_clr = 1'b0;
    #2;

    // reset and idle
    step_a();
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 10; i++) step_a();

    // fill 0..63
    for (int i = 0; i < 64; i++) begin
      drive_a(1'b1, 1'b0, 32'(i), 1'b0);
      step_a();
    end
    chk("fill_full",  64'(qa.full),  64'd1);
    chk("fill_count", 64'(qa.count), 64'd64);

    // overflow, clear, then simultaneous write/read at full
    drive_a(1'b1, 1'b0, 32'hDEAD, 1'b0);
    step_a();
    chk("ovf_set", 64'(qa.overflow), 64'd1);
    drive_a(1'b0, 1'b0, 32'h0, 1'b1);
    step_a();
    chk("ovf_clr", 64'(qa.overflow), 64'd0);
    drive_a(1'b1, 1'b1, 32'hBEEF, 1'b0);
    step_a();
    chk("full_rw_count", 64'(qa.count), 64'd64);
    for (int i = 0; i < 63; i++) begin
      drive_a(1'b0, 1'b1, 32'h0, 1'b0);
      step_a();
    end
    chk("beef_head", 64'(qa.dout), 64'hBEEF);
    drive_a(1'b0, 1'b1, 32'h0, 1'b0);
    step_a();
    chk("drained", 64'(qa.empty), 64'd1);

    // underflow with coincident write
    drive_a(1'b1, 1'b1, 32'h55, 1'b0);
    step_a();
    chk("udf_set",   64'(qa.underflow), 64'd1);
    chk("udf_dout",  64'(qa.dout),      64'h55);
    drive_a(1'b0, 1'b1, 32'h0, 1'b0);
    step_a();
    chk("udf_sticky", 64'(qa.underflow), 64'd1);
    chk("udf_count",  64'(qa.count),     64'd0);

    // random traffic, long enough for several pointer wraps
    for (int i = 0; i < 600; i++) begin
      drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
              ($urandom_range(0, 15) == 0));
      step_a();
    end

    // reset mid-operation with count 17
    drive_a(1'b0, 1'b1, 32'h0, 1'b0);
    rst_a = 1'b1;
    step_a();
    rst_a = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive_a(1'b1, 1'b0, 32'h1000 + 32'(i), 1'b0);
      step_a();
    end
    chk("pre_rst_count", 64'(qa.count), 64'd17);
    drive_a(1'b1, 1'b0, 32'hBAD0, 1'b0);
    rst_a = 1'b1;
    step_a();
    rst_a = 1'b0;
    chk("rst_count", 64'(qa.count), 64'd0);
    chk("rst_empty", 64'(qa.empty), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 1'b0, 32'h2000 + 32'(i), 1'b0);
      step_a();
    end
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_dout", 64'(qa.dout), 64'h2000 + 64'(i));
      drive_a(1'b0, 1'b1, 32'h0, 1'b0);
      step_a();
    end
    drive_a(1'b0, 1'b0, 32'h0, 1'b0);

    // small instance: WIDTH=8, AW=3
    for (int i = 0; i < 8; i++) begin
      bdat[i] = 8'($urandom());
      qb.wr_en = 1'b1;
      qb.din   = bdat[i];
      step_b();
      chk("b_count", 64'(qb.count),       64'(i + 1));
      chk("b_full",  64'(qb.full),        64'(i == 7));
      chk("b_afull", 64'(qb.almost_full), 64'(i + 1 >= 4));
    end
    qb.wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("b_dout", 64'(qb.dout), 64'(bdat[i]));
      qb.rd_en = 1'b1;
      step_b();
    end
    qb.rd_en = 1'b0;
    chk("b_empty", 64'(qb.empty), 64'd1);
    for (int i = 0; i < 5; i++) begin
      qb.wr_en = 1'b1;
      qb.din   = 8'(i);
      step_b();
    end
    qb.din = 8'hEE;
    rst_b  = 1'b1;
    step_b();
    rst_b    = 1'b0;
    qb.wr_en = 1'b0;
    chk("b_rst_count", 64'(qb.count), 64'd0);
    chk("b_rst_empty", 64'(qb.empty), 64'd1);
    qb.wr_en = 1'b1;
    qb.din   = 8'h3C;
    step_b();
    qb.wr_en = 1'b0;
    chk("b_post_rst_dout", 64'(qb.dout), 64'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
